// File: rtl/camera_capture_window.sv
// DVP capture front end: arms on shutter, syncs to vsync, captures a row window,
// packs bytes into OUT_W-bit words (first byte in [7:0]) and streams them over valid/ready.
// Ports: pclk/reset (sync, active-high); href, vsync, d from the sensor; shutter and
// cfg_* control; out_data/out_valid/out_ready stream; busy, frame_done, short_frame and
// overflow status.
module camera_capture_window #(
  parameter int unsigned LINE_BYTES = 1280,
  parameter int unsigned ROW_W      = 9,
  parameter int unsigned OUT_W      = 32
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             href,
  input  logic             vsync,
  input  logic [7:0]       d,
  input  logic             shutter,
  input  logic [ROW_W-1:0] cfg_row_first,
  input  logic [ROW_W-1:0] cfg_row_last,
  input  logic             cfg_continuous,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             short_frame,
  output logic             overflow
);

  localparam int unsigned LANES  = OUT_W / 8;
  localparam int unsigned PACK_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned BYTE_W = $clog2(LINE_BYTES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, FRAME, DONE} state_t;

  state_t state, state_next;

  logic             href_q, vsync_q;
  logic [ROW_W-1:0] row, row_first, row_last;
  logic             continuous;
  logic [BYTE_W-1:0] byte_cnt;
  logic [PACK_W-1:0] pack_cnt;
  logic [OUT_W-1:0] pack;
  logic [OUT_W-1:0] word;
  logic             vsync_rise, href_fall, in_window, take_byte, word_done, accept, last_row_end;

  always_comb begin
    vsync_rise   = vsync & ~vsync_q;
    href_fall    = href_q & ~href;
    in_window    = (row >= row_first) && (row <= row_last);
    take_byte    = (state == FRAME) && href && in_window && (byte_cnt < BYTE_W'(LINE_BYTES));
    word_done    = take_byte && (pack_cnt == PACK_W'(LANES - 1));
    accept       = out_valid && out_ready;
    last_row_end = href_fall && (row == row_last);
    word = pack;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (pack_cnt == PACK_W'(i)) word[i*8 +: 8] = d;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (shutter) state_next = ARMED;
      end
      ARMED: begin
        busy = 1'b1;
        if (vsync_rise) state_next = FRAME;
      end
      FRAME: begin
        busy = 1'b1;
        if (last_row_end || vsync_rise) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = (continuous && shutter) ? ARMED : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state       <= IDLE;
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      row         <= '0;
      row_first   <= '0;
      row_last    <= '0;
      continuous  <= 1'b0;
      byte_cnt    <= '0;
      pack_cnt    <= '0;
      pack        <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      short_frame <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state   <= state_next;
      href_q  <= href;
      vsync_q <= vsync;

      if (state == IDLE && shutter) begin
        short_frame <= 1'b0;
        overflow    <= 1'b0;
        row_first   <= cfg_row_first;
        row_last    <= cfg_row_last;
        continuous  <= cfg_continuous;
      end

      if (state == ARMED && vsync_rise) begin
        row      <= '0;
        byte_cnt <= '0;
        pack_cnt <= '0;
      end

      if (state == FRAME) begin
        // A falling href also throws away any partial word in the pack register.
        if (href_fall) begin
          byte_cnt <= '0;
          pack_cnt <= '0;
          if (row != '1) row <= row + 1'b1;
        end else if (href && byte_cnt < BYTE_W'(LINE_BYTES)) begin
          byte_cnt <= byte_cnt + 1'b1;
        end
        if (take_byte) begin
          pack     <= word;
          pack_cnt <= word_done ? '0 : pack_cnt + 1'b1;
        end
        if (vsync_rise && !last_row_end) short_frame <= 1'b1;
      end

      // Completion on an accept edge refills the slot; completion against a stalled
      // slot is dropped and flagged.
      if (word_done) begin
        if (!out_valid || out_ready) begin
          out_data  <= word;
          out_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_camera_capture_window.sv
module tb_camera_capture_window;

  localparam int unsigned LB = 8;

  logic        pclk = 1'b0;
  logic        reset;
  logic        href, vsync, shutter, cfg_continuous, out_ready;
  logic [7:0]  d;
  logic [8:0]  cfg_row_first, cfg_row_last;
  logic [31:0] out_data;
  logic        out_valid, busy, frame_done, short_frame, overflow;

  camera_capture_window #(.LINE_BYTES(LB), .ROW_W(9), .OUT_W(32)) dut (
    .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .d(d), .shutter(shutter),
    .cfg_row_first(cfg_row_first), .cfg_row_last(cfg_row_last), .cfg_continuous(cfg_continuous),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .frame_done(frame_done), .short_frame(short_frame), .overflow(overflow)
  );

  always #5 pclk = ~pclk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned done_cnt = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  pix [0:7][0:15];
  int unsigned line_len [0:7];
  int ready_row = -1;
  int ready_byte = -1;

  // Observe at the falling edge: a valid&&ready seen here is accepted on the next rising edge.
  always @(negedge pclk) begin
    if (!reset) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (frame_done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 8; r++) begin
      line_len[r] = LB;
      for (int b = 0; b < 16; b++) pix[r][b] = 8'(r * 16 + b);
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 8; r++) begin
      line_len[r] = LB;
      for (int b = 0; b < 16; b++) pix[r][b] = 8'($urandom);
    end
  endtask

  // Expected words: every full group of 4 bytes among the first LB bytes of each window row that was sent.
  task automatic model_frame(input int unsigned first, input int unsigned last, input int unsigned nsent);
    for (int unsigned r = first; r <= last && r < nsent; r++) begin
      int unsigned n;
      n = (line_len[r] < LB) ? line_len[r] : LB;
      for (int unsigned w = 0; w < n / 4; w++)
        exp_q.push_back({pix[r][4*w+3], pix[r][4*w+2], pix[r][4*w+1], pix[r][4*w]});
    end
  endtask

  task automatic vsync_pulse();
    step(); vsync = 1'b1;
    step();
    step(); vsync = 1'b0;
    steps(2);
  endtask

  task automatic send_line(input int unsigned r);
    for (int unsigned b = 0; b < line_len[r]; b++) begin
      step();
      href = 1'b1;
      d = pix[r][b];
      if (int'(r) == ready_row && int'(b) == ready_byte) out_ready = 1'b1;
    end
    step(); href = 1'b0; d = '0;
    steps(2);
  endtask

  task automatic send_lines(input int unsigned from, input int unsigned to);
    for (int unsigned r = from; r < to; r++) send_line(r);
  endtask

  task automatic arm(input int unsigned first, input int unsigned last, input logic cont);
    cfg_row_first = 9'(first);
    cfg_row_last = 9'(last);
    cfg_continuous = cont;
    step(); shutter = 1'b1;
    step(); shutter = 1'b0;
  endtask

  task automatic compare_words(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic clear_scoreboard();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; href = 1'b0; vsync = 1'b0; d = '0; shutter = 1'b0;
    cfg_continuous = 1'b0; cfg_row_first = '0; cfg_row_last = '0; out_ready = 1'b1;
    steps(3);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_frame_done", 64'(frame_done), 64'h0);
    chk("rst_short", 64'(short_frame), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    reset = 1'b0;
    step();

    // T1 single shot, ramp data, rows 2..3
    clear_scoreboard();
    fill_ramp();
    arm(2, 3, 1'b0);
    chk("t1_busy_armed", 64'(busy), 64'h1);
    vsync_pulse();
    send_lines(0, 6);
    steps(4);
    model_frame(2, 3, 6);
    compare_words("t1");
    if (got_q.size() == 4) begin
      chk("t1_first_const", 64'(got_q[0]), 64'h23222120);
      chk("t1_last_const", 64'(got_q[3]), 64'h37363534);
    end
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_busy_idle", 64'(busy), 64'h0);
    chk("t1_short", 64'(short_frame), 64'h0);
    chk("t1_overflow", 64'(overflow), 64'h0);

    // T2 backpressure throughout
    clear_scoreboard();
    fill_ramp();
    out_ready = 1'b0;
    arm(2, 3, 1'b0);
    vsync_pulse();
    send_lines(0, 2);
    chk("t2_overflow_pre", 64'(overflow), 64'h0);
    send_lines(2, 6);
    steps(4);
    chk("t2_valid_held", 64'(out_valid), 64'h1);
    chk("t2_data_held", 64'(out_data), 64'h23222120);
    chk("t2_overflow", 64'(overflow), 64'h1);
    chk("t2_no_accepts", 64'(got_q.size()), 64'd0);
    out_ready = 1'b1;
    steps(3);
    exp_q.push_back(32'h23222120);
    compare_words("t2_drain");
    chk("t2_valid_drop", 64'(out_valid), 64'h0);

    // T3 short frame: window 2..5, vsync after row 3
    clear_scoreboard();
    fill_random();
    arm(2, 5, 1'b0);
    vsync_pulse();
    send_lines(0, 4);
    chk("t3_short_pre", 64'(short_frame), 64'h0);
    vsync_pulse();
    steps(3);
    model_frame(2, 5, 4);
    compare_words("t3");
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);
    chk("t3_short", 64'(short_frame), 64'h1);
    chk("t3_overflow", 64'(overflow), 64'h0);
    chk("t3_busy", 64'(busy), 64'h0);

    // T4 continuous, three frames; shutter dropped inside frame 3
    clear_scoreboard();
    cfg_row_first = 9'd2; cfg_row_last = 9'd3; cfg_continuous = 1'b1;
    step(); shutter = 1'b1;
    step();
    chk("t4_short_cleared", 64'(short_frame), 64'h0);
    for (int f = 0; f < 3; f++) begin
      fill_random();
      vsync_pulse();
      if (f == 2) shutter = 1'b0;
      send_lines(0, 6);
      model_frame(2, 3, 6);
      if (f < 2) chk($sformatf("t4_busy_f%0d", f), 64'(busy), 64'h1);
    end
    steps(3);
    chk("t4_busy_idle", 64'(busy), 64'h0);
    fill_random();
    vsync_pulse();
    send_lines(0, 6);
    steps(3);
    compare_words("t4");
    chk("t4_done_cnt", 64'(done_cnt), 64'd3);
    chk("t4_busy_end", 64'(busy), 64'h0);

    // T5 partial and over-long lines, window 1..4
    clear_scoreboard();
    fill_random();
    line_len[1] = 6; line_len[2] = 11; line_len[3] = 3; line_len[4] = 8;
    arm(1, 4, 1'b0);
    vsync_pulse();
    send_lines(0, 6);
    steps(3);
    model_frame(1, 4, 6);
    chk("t5_expected_total", 64'(exp_q.size()), 64'd5);
    compare_words("t5");
    chk("t5_overflow", 64'(overflow), 64'h0);

    // T7 word completes on the same edge as the accept of the held word
    clear_scoreboard();
    fill_random();
    out_ready = 1'b0;
    ready_row = 2; ready_byte = 7;
    arm(2, 3, 1'b0);
    vsync_pulse();
    send_lines(0, 6);
    steps(3);
    ready_row = -1; ready_byte = -1;
    model_frame(2, 3, 6);
    compare_words("t7");
    chk("t7_overflow", 64'(overflow), 64'h0);

    // T6 reset during row 2 byte 5 with a pending word
    clear_scoreboard();
    fill_random();
    out_ready = 1'b0;
    arm(0, 3, 1'b0);
    vsync_pulse();
    send_lines(0, 2);
    for (int b = 0; b < 6; b++) begin
      step();
      href = 1'b1;
      d = pix[2][b];
      if (b == 5) begin
        chk("t6_valid_pre", 64'(out_valid), 64'h1);
        chk("t6_overflow_pre", 64'(overflow), 64'h1);
        reset = 1'b1;
      end
    end
    step();
    chk("t6_valid", 64'(out_valid), 64'h0);
    chk("t6_busy", 64'(busy), 64'h0);
    chk("t6_overflow", 64'(overflow), 64'h0);
    chk("t6_short", 64'(short_frame), 64'h0);
    chk("t6_frame_done", 64'(frame_done), 64'h0);
    reset = 1'b0;
    out_ready = 1'b1;
    d = pix[2][7];
    step(); href = 1'b0; d = '0;
    steps(2);
    send_lines(3, 6);
    vsync_pulse();
    send_lines(0, 6);
    steps(3);
    compare_words("t6_quiet");
    chk("t6_done_cnt", 64'(done_cnt), 64'd0);
    chk("t6_valid_end", 64'(out_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
